scroll_display: RTL and testbench

SCROLL_DISPLAY -- requirements
Module: scroll_display

---
 rtl/scroll_display_pkg.sv | 33 +++
 rtl/tick_divider.sv | 35 +++
 rtl/scroll_display.sv | 113 +++++++++++
 tb/tb_scroll_display.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_display_pkg.sv
//==============================================================================
// scroll_display_pkg -- segment encoding and default dividers. Rev 1.0
//==============================================================================
`default_nettype none

package scroll_display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int SIM_SCAN_DIV  = 400;
  localparam int SIM_SHIFT_DIV = 16;
  localparam int HW_SCAN_DIV   = 250000;
  localparam int HW_SHIFT_DIV  = 200;

  // Entry n holds {g,f,e,d,c,b,a} for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
//==============================================================================
// tick_divider -- enable-gated wrapping counter with a runtime limit. Rev 1.0
//==============================================================================
`default_nettype none

module tick_divider #(
  parameter int N     = 16,
  parameter int WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic             at_limit;

  // The N-1 term keeps the counter inside its natural range even if limit is out of bounds.
  assign at_limit = (count >= limit) || (count == WIDTH'(N - 1));
  assign tick     = en && at_limit && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (at_limit) count <= '0;
      else          count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scroll_display.sv
//==============================================================================
// scroll_display -- rotating hex message on a multiplexed 7-segment display. Rev 1.0
//==============================================================================
`default_nettype none

module scroll_display
  import scroll_display_pkg::*;
#(
  parameter int                   SIM       = 0,
  parameter int                   DIGITS    = 4,
  parameter int                   MSG_LEN   = 13,
  parameter logic [4*MSG_LEN-1:0] INIT      = '0,
  parameter int                   SCAN_DIV  = (SIM != 0) ? SIM_SCAN_DIV  : HW_SCAN_DIV,
  parameter int                   SHIFT_DIV = (SIM != 0) ? SIM_SHIFT_DIV : HW_SHIFT_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   dir,
  input  logic [1:0]             spd,
  input  logic                   load,
  input  logic [4*MSG_LEN-1:0]   msg_in,
  output logic [4*MSG_LEN-1:0]   msg,
  output logic [DIGITS-1:0]      pos,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   e,
  output logic                   f,
  output logic                   g
);

  localparam int MW      = 4 * MSG_LEN;
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int SHIFT_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int WIN_LO  = MSG_LEN - DIGITS;

  logic               scan_tick;
  logic               shift_tick;
  logic [31:0]        shift_period;
  logic [SHIFT_W-1:0] shift_limit;
  logic               shift_clr;
  logic [3:0]         nib;
  logic [6:0]         segs;

  tick_divider #(
    .N     (SCAN_DIV),
    .WIDTH (SCAN_W)
  ) u_scan_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .limit (SCAN_W'(SCAN_DIV - 1)),
    .tick  (scan_tick)
  );

  // Speed is re-evaluated every cycle so a lowered limit fires on the next scan tick.
  assign shift_period = 32'(SHIFT_DIV) >> spd;
  assign shift_limit  = (shift_period == 32'd0) ? '0 : SHIFT_W'(shift_period - 32'd1);
  // A load restarts the shift period; it also masks the tick in its own cycle.
  assign shift_clr    = reset || load;

  tick_divider #(
    .N     (SHIFT_DIV),
    .WIDTH (SHIFT_W)
  ) u_shift_div (
    .clk   (clk),
    .reset (shift_clr),
    .en    (scan_tick && en),
    .limit (shift_limit),
    .tick  (shift_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      msg <= INIT;
    end else if (load) begin
      msg <= msg_in;
    end else if (shift_tick) begin
      if (!dir) msg <= {msg[MW-5:0], msg[MW-1:MW-4]};
      else      msg <= {msg[3:0], msg[MW-1:4]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= DIGITS'(1);
    end else if (scan_tick) begin
      pos <= {pos[DIGITS-2:0], pos[DIGITS-1]};
    end
  end

  // Digit k shows nibble WIN_LO+k; pos is one-hot so OR-ing the masked nibbles is a mux.
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (pos[k]) nib = nib | msg[4*(WIN_LO+k) +: 4];
    end
  end

  assign segs = hex_to_seg(nib);
  assign a    = segs[SEG_A];
  assign b    = segs[SEG_B];
  assign c    = segs[SEG_C];
  assign d    = segs[SEG_D];
  assign e    = segs[SEG_E];
  assign f    = segs[SEG_F];
  assign g    = segs[SEG_G];

endmodule

`default_nettype wire

// File: tb/tb_scroll_display.sv
//==============================================================================
// tb_scroll_display -- scoreboard bench for scroll_display (SIM dividers). Rev 1.0
//==============================================================================
`default_nettype none

module tb_scroll_display;

  localparam logic [51:0] INIT_V = 52'h0123456789ABC;
  localparam logic [51:0] LOAD_V = 52'hFEDCBA9876543;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        dir = 1'b0;
  logic [1:0]  spd = 2'd0;
  logic        load = 1'b0;
  logic [51:0] msg_in = '0;
  logic [51:0] msg;
  logic [3:0]  pos;
  logic        a, b, c, d, e, f, g;
  logic [6:0]  seg_now;

  scroll_display #(
    .SIM     (1),
    .DIGITS  (4),
    .MSG_LEN (13),
    .INIT    (INIT_V)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .dir    (dir),
    .spd    (spd),
    .load   (load),
    .msg_in (msg_in),
    .msg    (msg),
    .pos    (pos),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .e      (e),
    .f      (f),
    .g      (g)
  );

  assign seg_now = {g, f, e, d, c, b, a};

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [51:0] val;
    int unsigned edge_n;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [51:0] cur = INIT_V;
  logic [51:0] prev;
  bit          mon_on = 1'b0;
  int unsigned r0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [51:0] rotl(input logic [51:0] m);
    return {m[47:0], m[51:48]};
  endfunction

  task automatic push(input logic [51:0] v, input int unsigned edge_n);
    exp_t x;
    x.val    = v;
    x.edge_n = edge_n;
    sb.push_back(x);
    cur = v;
  endtask

  task automatic wait_edge(input int unsigned edge_n);
    while (cyc < edge_n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    if (cur !== INIT_V) push(INIT_V, cyc + 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    r0 = cyc;
  endtask

  // Every observed message change must match the next queued expectation, value and edge.
  always @(negedge clk) begin
    exp_t x;
    if (mon_on && msg !== prev) begin
      if (sb.size() == 0) begin
        check_val("msg_spurious", 64'(msg), 64'(prev));
      end else begin
        x = sb.pop_front();
        check_val("msg_val", 64'(msg), 64'(x.val));
        check_val("msg_edge", 64'(cyc), 64'(x.edge_n));
      end
      prev = msg;
    end
  end

  initial begin
    // Reset state and one left shift at speed 0
    @(posedge clk);
    #1;
    reset = 1'b0;
    r0 = cyc;
    prev = msg;
    mon_on = 1'b1;
    check_val("rst_msg", 64'(msg), 64'(INIT_V));
    check_val("rst_pos", 64'(pos), 64'h1);
    check_val("rst_seg", 64'(seg_now), 64'(seg_of(4'h3)));
    en = 1'b1;
    push(52'h123456789ABC0, r0 + 6400);
    wait_edge(r0 + 6410);
    check_val("a_window", 64'(msg[51:36]), 64'h1234);
    check_val("a_pos", 64'(pos), 64'h1);
    check_val("a_seg", 64'(seg_now), 64'(seg_of(4'h4)));
    check_val("a_sb", 64'(sb.size()), 64'd0);

    // Right shift
    dir = 1'b1;
    do_reset();
    push(52'hC0123456789AB, r0 + 6400);
    wait_edge(r0 + 801);
    check_val("b_pos", 64'(pos), 64'h4);
    check_val("b_seg_d2", 64'(seg_now), 64'(seg_of(4'h1)));
    wait_edge(r0 + 6402);
    check_val("b_seg_d0", 64'(seg_now), 64'(seg_of(4'h2)));

    // Speed 2, then a live switch to speed 3 with the count above the new limit
    dir = 1'b0;
    spd = 2'd2;
    do_reset();
    push(rotl(INIT_V), r0 + 1600);
    push(rotl(rotl(INIT_V)), r0 + 3200);
    wait_edge(r0 + 3201);
    spd = 2'd0;
    wait_edge(r0 + 5201);
    spd = 2'd3;
    push(rotl(cur), r0 + 5600);
    push(rotl(cur), r0 + 6400);
    wait_edge(r0 + 6401);
    check_val("c_msg", 64'(msg), 64'h456789ABC0123);

    // Pause: count held, scanning continues
    spd = 2'd0;
    do_reset();
    push(rotl(INIT_V), r0 + 19200);
    wait_edge(r0 + 3201);
    en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wait_edge(r0 + 3201 + 400 * j);
      check_val("d_pos", 64'(pos), 64'(4'b0001 << ((8 + j) % 4)));
    end
    wait_edge(r0 + 16001);
    check_val("d_hold", 64'(msg), 64'(INIT_V));
    en = 1'b1;
    wait_edge(r0 + 19201);
    check_val("d_resume", 64'(msg), 64'h123456789ABC0);

    // Load coincident with a shift tick wins and restarts the period
    do_reset();
    wait_edge(r0 + 6399);
    msg_in = LOAD_V;
    load = 1'b1;
    push(LOAD_V, r0 + 6400);
    wait_edge(r0 + 6400);
    load = 1'b0;
    push(rotl(LOAD_V), r0 + 12800);
    wait_edge(r0 + 12801);
    check_val("e_msg", 64'(msg), 64'hEDCBA9876543F);

    // Reset mid-period discards progress
    spd = 2'd3;
    do_reset();
    push(rotl(INIT_V), r0 + 800);
    wait_edge(r0 + 1000);
    do_reset();
    check_val("f_msg", 64'(msg), 64'(INIT_V));
    check_val("f_pos", 64'(pos), 64'h1);
    check_val("f_seg", 64'(seg_now), 64'(seg_of(4'h3)));
    wait_edge(r0 + 399);
    check_val("f_pos_pre", 64'(pos), 64'h1);
    wait_edge(r0 + 400);
    check_val("f_pos_tick", 64'(pos), 64'h2);

    @(negedge clk);
    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
